// File: rtl/mem_interface.sv
// Memory-side stage: address select, store lane steering, instruction/old-PC
// capture and load-data alignment into the MDR.
module mem_interface #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic            adr_src,
  input  logic            ir_write,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] mdr,
  output logic            align_err
);

  // Load request held across the memory's one-cycle read latency.
  typedef struct packed {
    logic [1:0] off;
    logic [2:0] f3;
  } ld_req_t;

  logic [XLEN-1:0] addr;
  logic [1:0]      off;
  logic            st_ok, fetch_req, fetch_ok, ld_req, ld_legal, ld_ok, err_now;
  logic            inst_pend, ld_pend;
  logic [XLEN-1:0] pc_q;
  ld_req_t         ld_q;
  logic [XLEN-1:0] lane, ld_val;

  // Size/offset legality shared by loads and stores (funct3[1:0] = size).
  function automatic logic size_ok(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~o[0];
      2'b10:   size_ok = (o == 2'b00);
      default: size_ok = 1'b0;
    endcase
  endfunction

  assign addr     = adr_src ? alu_out : pc;
  assign off      = addr[1:0];
  assign mem_addr = {addr[XLEN-1:2], 2'b00};

  assign st_ok     = mem_write & adr_src & size_ok(funct3[1:0], off);
  assign fetch_req = ir_write & ~adr_src;
  assign fetch_ok  = fetch_req & (pc[1:0] == 2'b00);
  assign ld_req    = adr_src & ~mem_write & ~ir_write;
  // 3'b110 has a word size field but no RV32 meaning; 011/111 fail size_ok.
  assign ld_legal  = size_ok(funct3[1:0], off) & (funct3 != 3'b110);
  assign ld_ok     = ld_req & ld_legal;
  assign err_now   = (mem_write & ~st_ok)
                   | (ir_write & adr_src)
                   | (fetch_req & ~fetch_ok)
                   | (ld_req & ~ld_legal);

  // Store strobes and lane-replicated data; strobes only on a legal store.
  always_comb begin
    mem_we    = st_ok;
    mem_wmask = 4'b0000;
    case (funct3[1:0])
      2'b00:   mem_wdata = {4{store_data[7:0]}};
      2'b01:   mem_wdata = {2{store_data[15:0]}};
      default: mem_wdata = store_data;
    endcase
    if (st_ok) begin
      case (funct3[1:0])
        2'b00:   mem_wmask = 4'b0001 << off;
        2'b01:   mem_wmask = 4'b0011 << off;
        default: mem_wmask = 4'b1111;
      endcase
    end
  end

  // Load extraction from the registered offset/funct3, never from live inputs.
  always_comb begin
    lane = mem_rdata >> {ld_q.off, 3'b000};
    case (ld_q.f3)
      3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_val = {24'd0, lane[7:0]};
      3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_val = {16'd0, lane[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  // Fetch: latch PC on the request edge, capture IR/old PC one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_pend <= 1'b0;
      pc_q      <= '0;
      instr     <= RESET_INSTR;
      old_pc    <= '0;
    end else begin
      inst_pend <= fetch_ok;
      if (fetch_ok) pc_q <= pc;
      if (inst_pend) begin
        instr  <= mem_rdata;
        old_pc <= pc_q;
      end
    end
  end

  // Load: latch access shape on the request edge, fill MDR one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pend <= 1'b0;
      ld_q    <= '0;
      mdr     <= '0;
    end else begin
      ld_pend <= ld_ok;
      if (ld_ok) ld_q <= '{off: off, f3: funct3};
      if (ld_pend) mdr <= ld_val;
    end
  end

  // Sticky access-violation flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       align_err <= 1'b0;
    else if (err_now) align_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_interface.sv
module tb_mem_interface;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, alu_out, store_data, mem_rdata;
  logic        adr_src, ir_write, mem_write;
  logic [2:0]  funct3;
  logic [31:0] mem_addr, mem_wdata, instr, old_pc, mdr;
  logic        mem_we, align_err;
  logic [3:0]  mem_wmask;

  mem_interface dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .alu_out(alu_out), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .funct3(funct3),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .instr(instr), .old_pc(old_pc), .mdr(mdr), .align_err(align_err)
  );

  always #5 clk = ~clk;

  typedef enum {K_ADDR, K_WE, K_MASK, K_WDATA, K_INSTR, K_OLDPC, K_MDR, K_ERR} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(kind_e k);
    case (k)
      K_ADDR:  actual = mem_addr;
      K_WE:    actual = {31'd0, mem_we};
      K_MASK:  actual = {28'd0, mem_wmask};
      K_WDATA: actual = mem_wdata;
      K_INSTR: actual = instr;
      K_OLDPC: actual = old_pc;
      K_MDR:   actual = mdr;
      default: actual = {31'd0, align_err};
    endcase
  endfunction

  // Monitor: retire every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] a;
        a = actual(sb[i].kind);
        n_tests++;
        if (a !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got %h, expected %h", sb[i].name, cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.due = cyc + dly; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    adr_src = 0; ir_write = 0; mem_write = 0; funct3 = 3'b000;
    pc = 0; alu_out = 0; store_data = 0; mem_rdata = 0;
  endtask

  // Pulse reset inside the current cycle and check the cleared state.
  task automatic do_reset();
    rst_n = 0;
    expect_at(0, K_ERR, 32'd0, "rst_err");
    expect_at(0, K_INSTR, 32'h13, "rst_instr");
    expect_at(0, K_MDR, 32'd0, "rst_mdr");
    @(negedge clk); #1;
    rst_n = 1;
    tick();
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] rd, input logic [31:0] exp_v, input string n);
    adr_src = 1; alu_out = a; funct3 = f3;
    expect_at(2, K_MDR, exp_v, n);
    tick();
    idle(); mem_rdata = rd;
    tick();
    mem_rdata = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] sd,
                       input logic [31:0] ea, input logic [3:0] em, input logic [31:0] ed,
                       input string n);
    adr_src = 1; mem_write = 1; alu_out = a; funct3 = f3; store_data = sd;
    expect_at(0, K_ADDR, ea, {n, "_addr"});
    expect_at(0, K_WE, 32'd1, {n, "_we"});
    expect_at(0, K_MASK, {28'd0, em}, {n, "_mask"});
    expect_at(0, K_WDATA, ed, {n, "_wdata"});
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) tick();
    expect_at(0, K_INSTR, 32'h0000_0013, "reset_instr");
    expect_at(0, K_OLDPC, 32'd0, "reset_old_pc");
    expect_at(0, K_MDR, 32'd0, "reset_mdr");
    expect_at(0, K_ERR, 32'd0, "reset_err");
    @(negedge clk); #1;
    rst_n = 1;
    tick();

    // Fetch from 0x40, data arrives the following cycle.
    pc = 32'h40; ir_write = 1;
    expect_at(0, K_ADDR, 32'h40, "fetch_addr");
    expect_at(0, K_WE, 32'd0, "fetch_we");
    expect_at(0, K_MASK, 32'd0, "fetch_mask");
    expect_at(1, K_INSTR, 32'h13, "fetch_instr_early");
    expect_at(2, K_INSTR, 32'h0050_0093, "fetch_instr");
    expect_at(2, K_OLDPC, 32'h40, "fetch_old_pc");
    expect_at(4, K_INSTR, 32'h0050_0093, "fetch_instr_hold");
    tick();
    idle(); mem_rdata = 32'h0050_0093;
    tick();
    idle();
    repeat (2) tick();

    n_tests++;
    if (instr !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL direct_fetch_instr: got %h", instr);
    end
    n_tests++;
    if (old_pc !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL direct_fetch_old_pc: got %h", old_pc);
    end

    // Stores of each size.
    store(32'h103, 3'b000, 32'hAABB_CCDD, 32'h100, 4'b1000, 32'hDDDD_DDDD, "sb");
    store(32'h102, 3'b001, 32'hAABB_CCDD, 32'h100, 4'b1100, 32'hCCDD_CCDD, "sh");
    store(32'h204, 3'b010, 32'hAABB_CCDD, 32'h204, 4'b1111, 32'hAABB_CCDD, "sw");

    // Loads with sign/zero extension and lane selection.
    load(32'h102, 3'b000, 32'h0080_0000, 32'hFFFF_FF80, "lb");
    load(32'h102, 3'b100, 32'h0080_0000, 32'h0000_0080, "lbu");
    load(32'h100, 3'b000, 32'h0000_007F, 32'h0000_007F, "lb_pos");
    load(32'h206, 3'b001, 32'hBEEF_1234, 32'hFFFF_BEEF, "lh");
    load(32'h204, 3'b101, 32'hBEEF_8234, 32'h0000_8234, "lhu_lo");
    load(32'h100, 3'b010, 32'h1234_5678, 32'h1234_5678, "lw");
    expect_at(0, K_ERR, 32'd0, "no_err_yet");

    n_tests++;
    if (mdr !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL direct_lw_mdr: got %h", mdr);
    end

    // Fetch leaves MDR alone.
    pc = 32'h80; ir_write = 1;
    expect_at(2, K_MDR, 32'h1234_5678, "mdr_hold_fetch");
    expect_at(2, K_INSTR, 32'h0000_0033, "fetch2_instr");
    expect_at(2, K_OLDPC, 32'h80, "fetch2_old_pc");
    tick();
    idle(); mem_rdata = 32'h0000_0033;
    tick();
    idle();

    // Reset between load edges drops the pending capture.
    adr_src = 1; alu_out = 32'h100; funct3 = 3'b010;
    tick();
    idle(); mem_rdata = 32'hCAFE_F00D;
    rst_n = 0;
    expect_at(0, K_MDR, 32'd0, "midrst_mdr");
    expect_at(0, K_INSTR, 32'h13, "midrst_instr");
    expect_at(1, K_MDR, 32'd0, "midrst_no_late");
    @(negedge clk); #1;
    rst_n = 1;
    tick();
    idle();
    tick();

    n_tests++;
    if (mdr !== 32'd0) begin
      n_fail++;
      $display("FAIL direct_midrst_mdr: got %h", mdr);
    end

    // Misaligned SW: no write, sticky error.
    adr_src = 1; mem_write = 1; alu_out = 32'h102; funct3 = 3'b010; store_data = 32'h1122_3344;
    expect_at(0, K_WE, 32'd0, "sw_mis_we");
    expect_at(0, K_MASK, 32'd0, "sw_mis_mask");
    expect_at(0, K_ERR, 32'd0, "sw_mis_err_pre");
    expect_at(1, K_ERR, 32'd1, "sw_mis_err");
    expect_at(5, K_ERR, 32'd1, "sw_mis_err_sticky");
    tick();
    idle();
    repeat (5) tick();

    n_tests++;
    if (align_err !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_sw_mis_sticky: got %b", align_err);
    end
    do_reset();

    // LHU aligned then misaligned: MDR holds on the bad one.
    load(32'h206, 3'b101, 32'hBEEF_1234, 32'h0000_BEEF, "lhu");
    adr_src = 1; alu_out = 32'h205; funct3 = 3'b101;
    expect_at(1, K_ERR, 32'd1, "lhu_mis_err");
    expect_at(2, K_MDR, 32'h0000_BEEF, "lhu_mis_hold");
    tick();
    idle(); mem_rdata = 32'h5555_5555;
    tick();
    idle();
    tick();
    do_reset();

    // Misaligned fetch: no IR capture.
    pc = 32'h42; ir_write = 1;
    expect_at(1, K_ERR, 32'd1, "fetch_mis_err");
    expect_at(2, K_INSTR, 32'h13, "fetch_mis_instr");
    tick();
    idle(); mem_rdata = 32'hDEAD_BEEF;
    tick();
    idle();
    tick();
    do_reset();

    // ir_write with ALU address select.
    adr_src = 1; ir_write = 1; alu_out = 32'h40;
    expect_at(1, K_ERR, 32'd1, "fetch_alu_err");
    expect_at(2, K_INSTR, 32'h13, "fetch_alu_instr");
    tick();
    idle(); mem_rdata = 32'hDEAD_BEEF;
    tick();
    idle();
    tick();
    do_reset();

    // Illegal load encoding.
    adr_src = 1; alu_out = 32'h100; funct3 = 3'b110;
    expect_at(1, K_ERR, 32'd1, "ld_ill_err");
    expect_at(2, K_MDR, 32'd0, "ld_ill_mdr");
    tick();
    idle(); mem_rdata = 32'hFFFF_FFFF;
    tick();
    idle();
    tick();
    do_reset();

    // Store with PC address select.
    mem_write = 1; pc = 32'h100; funct3 = 3'b010; store_data = 32'h0102_0304;
    expect_at(0, K_WE, 32'd0, "st_pc_we");
    expect_at(0, K_MASK, 32'd0, "st_pc_mask");
    expect_at(1, K_ERR, 32'd1, "st_pc_err");
    tick();
    idle();
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    while (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h", sb[0].name, sb[0].val);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
